// File: rtl/cdb_arbiter.sv
// Completion stage: buffers up to two EX results per cycle and broadcasts one per
// cycle on the common data bus, with round-robin priority and per-lane back-pressure.
module cdb_arbiter #(
  parameter int XLEN      = 32,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [1:0]                ex_valid,
  input  logic [1:0][XLEN-1:0]      ex_result,
  input  logic [1:0][XLEN-1:0]      ex_NPC,
  input  logic [1:0]                ex_take_branch,
  input  logic [1:0]                ex_reg_write,
  input  logic [1:0][PRF_IDX_W-1:0] ex_dest_PRF_idx,
  input  logic [1:0][ROB_IDX_W-1:0] ex_rob_idx,
  output logic [1:0]                CDB_hazard,
  output logic                      cdb_valid,
  output logic                      cdb_lane,
  output logic [XLEN-1:0]           cdb_value,
  output logic [XLEN-1:0]           cdb_NPC,
  output logic                      cdb_take_branch,
  output logic                      cdb_reg_write,
  output logic [PRF_IDX_W-1:0]      cdb_tag,
  output logic [ROB_IDX_W-1:0]      cdb_rob_idx
);

  logic [1:0]                buf_valid;
  logic [1:0][XLEN-1:0]      buf_result;
  logic [1:0][XLEN-1:0]      buf_npc;
  logic [1:0]                buf_take_branch;
  logic [1:0]                buf_reg_write;
  logic [1:0][PRF_IDX_W-1:0] buf_tag;
  logic [1:0][ROB_IDX_W-1:0] buf_rob_idx;
  logic                      rr_ptr;

  logic [1:0] grant;
  logic [1:0] load;
  logic       sel;

  // Grant uses registered state only; reset is folded in so outputs are quiet during reset.
  always_comb begin
    grant = 2'b00;
    if (!reset && !squash) begin
      if (&buf_valid) begin
        grant[rr_ptr] = 1'b1;
      end else begin
        grant = buf_valid;
      end
    end
  end

  always_comb begin
    CDB_hazard = 2'b00;
    if (!reset) begin
      CDB_hazard = buf_valid & ~grant;
    end
  end

  assign load = ex_valid & ~CDB_hazard;
  assign sel  = grant[1];

  always_comb begin
    cdb_valid       = 1'b0;
    cdb_lane        = 1'b0;
    cdb_value       = '0;
    cdb_NPC         = '0;
    cdb_take_branch = 1'b0;
    cdb_reg_write   = 1'b0;
    cdb_tag         = '0;
    cdb_rob_idx     = '0;
    if (|grant) begin
      cdb_valid       = 1'b1;
      cdb_lane        = sel;
      cdb_value       = buf_result[sel];
      cdb_NPC         = buf_npc[sel];
      cdb_take_branch = buf_take_branch[sel];
      cdb_reg_write   = buf_reg_write[sel];
      cdb_tag         = buf_tag[sel];
      cdb_rob_idx     = buf_rob_idx[sel];
    end
  end

  // A granted buffer may be refilled on the same edge, so load takes precedence over drain.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid       <= '0;
      buf_result      <= '0;
      buf_npc         <= '0;
      buf_take_branch <= '0;
      buf_reg_write   <= '0;
      buf_tag         <= '0;
      buf_rob_idx     <= '0;
      rr_ptr          <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (squash) begin
          buf_valid[i] <= 1'b0;
        end else if (load[i]) begin
          buf_valid[i]       <= 1'b1;
          buf_result[i]      <= ex_result[i];
          buf_npc[i]         <= ex_NPC[i];
          buf_take_branch[i] <= ex_take_branch[i];
          buf_reg_write[i]   <= ex_reg_write[i];
          buf_tag[i]         <= ex_dest_PRF_idx[i];
          buf_rob_idx[i]     <= ex_rob_idx[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      if (|grant) begin
        rr_ptr <= ~sel;
      end
    end
  end

`ifndef SYNTHESIS
  // Execute stage must never present a result on a lane it has been told to hold.
  protocol_hold_check: assert property (
    @(posedge clock) disable iff (reset || squash) (ex_valid & CDB_hazard) == 2'b00
  );
`endif

endmodule
